// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the front-panel control stage that drives
// the 4-bit up/down counter.
package counter_ctrl_pkg;

  localparam int CNT_W = 4;

  // Slot of each button in the per-button vectors inside the top level.
  localparam int BTN_UP   = 0;
  localparam int BTN_DOWN = 1;
  localparam int BTN_LOAD = 2;
  localparam int BTN_RUN  = 3;
  localparam int NUM_BTN  = 4;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_AUTO   = 1'b1
  } mode_e;

  function automatic mode_e toggle_mode(input mode_e mode);
    return (mode == MODE_AUTO) ? MODE_MANUAL : MODE_AUTO;
  endfunction

endpackage

// File: rtl/counter_ctrl_if.sv
// Front-panel bundle: raw buttons and switches in, counter controls out.
// The master drives the panel side; the controller attaches as the slave.
interface counter_ctrl_if;
  import counter_ctrl_pkg::*;

  logic             btn_up;
  logic             btn_down;
  logic             btn_load;
  logic             btn_run;
  logic [CNT_W-1:0] sw;

  logic             load;
  logic             enable;
  logic             up_down;
  logic [CNT_W-1:0] d_in;
  logic             run_active;

  modport master (
    output btn_up, btn_down, btn_load, btn_run, sw,
    input  load, enable, up_down, d_in, run_active
  );

  modport slave (
    input  btn_up, btn_down, btn_load, btn_run, sw,
    output load, enable, up_down, d_in, run_active
  );

endinterface

// File: rtl/btn_debounce.sv
// One push-button channel: 2-flop synchroniser, stability debouncer and
// rising-edge press detector. The press pulse is registered with the level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic [DB_W-1:0] cnt_q, cnt_d;

  // NOTE: non-blocking assignments let every flop sample the pre-edge value,
  // which is what makes the two synchroniser stages two distinct delays.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  // The count only survives while the synchronised input keeps disagreeing
  // with the accepted level; the N-th consecutive disagreement flips it.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == DB_LAST) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/counter_ctrl.sv
// Front-panel controller: debounced buttons become registered load/enable
// pulses, a direction level and a latched load value, with an auto-run mode.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int TICK_DIV        = 25000000
) (
  input  logic           clk,
  input  logic           rst_n,
  counter_ctrl_if.slave  bus
);

  localparam int              PS_W    = $clog2(TICK_DIV);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;

  logic [CNT_W-1:0] sw_sync1_q, sw_sync2_q;

  mode_e            mode_q, mode_d;
  logic             dir_q, dir_d;
  logic [PS_W-1:0]  presc_q, presc_d;
  logic [CNT_W-1:0] d_in_q, d_in_d;
  logic             load_q, load_d;
  logic             enable_q, enable_d;

  logic step_up, step_down, tick;

  assign btn_raw[BTN_UP]   = bus.btn_up;
  assign btn_raw[BTN_DOWN] = bus.btn_down;
  assign btn_raw[BTN_LOAD] = bus.btn_load;
  assign btn_raw[BTN_RUN]  = bus.btn_run;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_raw (btn_raw[g]),
      .level   (btn_level[g]),
      .press   (btn_press[g])
    );
  end

  // A press is only ever raised together with its debounced level going high.
  a_press_has_level: assert property (
    @(posedge clk) disable iff (!rst_n) (btn_press & ~btn_level) == '0
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_sync1_q <= '0;
      sw_sync2_q <= '0;
      mode_q     <= MODE_MANUAL;
      dir_q      <= 1'b1;
      presc_q    <= '0;
      d_in_q     <= '0;
      load_q     <= 1'b0;
      enable_q   <= 1'b0;
    end else begin
      sw_sync1_q <= bus.sw;
      sw_sync2_q <= sw_sync1_q;
      mode_q     <= mode_d;
      dir_q      <= dir_d;
      presc_q    <= presc_d;
      d_in_q     <= d_in_d;
      load_q     <= load_d;
      enable_q   <= enable_d;
    end
  end

  // Up and down pressed together cancel each other completely.
  assign step_up   = btn_press[BTN_UP]   & ~btn_press[BTN_DOWN];
  assign step_down = btn_press[BTN_DOWN] & ~btn_press[BTN_UP];
  assign tick      = (mode_q == MODE_AUTO) && (presc_q == PS_LAST);

  always_comb begin
    mode_d   = mode_q;
    dir_d    = dir_q;
    presc_d  = presc_q;
    d_in_d   = d_in_q;
    load_d   = 1'b0;
    enable_d = 1'b0;

    if (step_up) begin
      dir_d = 1'b1;
    end else if (step_down) begin
      dir_d = 1'b0;
    end

    unique case (mode_q)
      MODE_MANUAL: begin
        enable_d = step_up | step_down;
      end
      MODE_AUTO: begin
        enable_d = tick;
        presc_d  = tick ? '0 : presc_q + 1'b1;
      end
      default: ;
    endcase

    // Entering or leaving auto-run restarts the prescaler; a tick on the
    // leaving edge is dropped so no step follows the exit.
    if (btn_press[BTN_RUN]) begin
      mode_d  = toggle_mode(mode_q);
      presc_d = '0;
      if (mode_q == MODE_AUTO) begin
        enable_d = 1'b0;
      end
    end

    // Load wins over any step or tick in the same cycle.
    if (btn_press[BTN_LOAD]) begin
      load_d   = 1'b1;
      d_in_d   = sw_sync2_q;
      enable_d = 1'b0;
      presc_d  = '0;
    end
  end

  assign bus.load       = load_q;
  assign bus.enable     = enable_q;
  assign bus.up_down    = dir_q;
  assign bus.d_in       = d_in_q;
  assign bus.run_active = (mode_q == MODE_AUTO);

endmodule
